serial_subtractor: RTL and testbench

//   Bit-serial N-bit subtractor: diff = a - b, one bit per clock, LSB first.

---
 rtl/serial_subtractor_pkg.sv | 22 ++
 rtl/full_subtractor.sv | 21 ++
 rtl/serial_subtractor.sv | 145 ++++++++++++++
 tb/tb_serial_subtractor.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package serial_subtractor_pkg;

    // Control FSM states; encoding is fixed so that debug probes decode consistently.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Default operand width and the matching bit-counter width.
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    // Bit-counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow the inputs.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic w_axb;

    // Difference bit and borrow out.
    always_comb begin
        w_axb = a ^ b;
        d     = w_axb ^ bin;
        bout  = (~a & b) | (~w_axb & bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, LSB first); optional ovf port under SERIAL_SUBTRACTOR_OVF_EN.
// Latency: start accepted at edge T -> done pulse in the cycle after edge T+WIDTH+1.
// Backpressure: start is only sampled in IDLE; a start while busy is dropped, never queued.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff_sr;
    logic             r_bin;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             w_d;
    logic             w_bout;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand sign bits are shifted out of the operand registers, so keep a copy.
    logic r_a_msb;
    logic r_b_msb;
    logic r_ovf;
`endif

    // The single shared subtract cell, fed from the low end of the operand registers.
    full_subtractor u_cell (
        .a    (r_a_sr[0]),
        .b    (r_b_sr[0]),
        .bin  (r_bin),
        .d    (w_d),
        .bout (w_bout)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, walk WIDTH bits, then one DONE cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == LAST_BIT) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture and per-bit shift datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_diff_sr <= '0;
            r_bin     <= 1'b0;
            r_cnt     <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_a_msb   <= 1'b0;
            r_b_msb   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr    <= a;
                        r_b_sr    <= b;
                        r_diff_sr <= '0;
                        r_bin     <= 1'b0;
                        r_cnt     <= '0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                        r_a_msb   <= a[WIDTH-1];
                        r_b_msb   <= b[WIDTH-1];
`endif
                    end
                end
                SHIFT: begin
                    // Results enter at the MSB so the first (LSB) bit ends at bit 0.
                    r_diff_sr <= {w_d, r_diff_sr[WIDTH-1:1]};
                    r_a_sr    <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr    <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_bin     <= w_bout;
                    r_cnt     <= r_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Result registers: loaded while in DONE, then held until the next result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            r_ovf    <= 1'b0;
`endif
        end else begin
            r_done <= (r_state == DONE);
            if (r_state == DONE) begin
                r_diff   <= r_diff_sr;
                r_borrow <= r_bin;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                r_ovf    <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ r_diff_sr[WIDTH-1]);
`endif
            end
        end
    end

    assign busy   = (r_state != IDLE);
    assign done   = r_done;
    assign diff   = r_diff;
    assign borrow = r_borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed corner cases plus random operands vs an arithmetic model.
// Latency: checks done arrives exactly WIDTH+1 cycles after the accepting edge.
// Backpressure: checks that start while busy is dropped and reset aborts at once.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic         ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one subtraction; optionally pulses a competing start at cycle inj after acceptance.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input int inj);
        int          r;
        int          k;
        logic [31:0] ed;
        logic        eb;
        logic        eo;
        r  = int'(ta) - int'(tb);
        ed = 32'(r) & 32'hFF;
        eb = (r < 0);
        r  = int'($signed(ta)) - int'($signed(tb));
        eo = (r > 127) || (r < -128);
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Operands changing after acceptance must not disturb the running subtraction.
        a = W'($urandom); b = W'($urandom);
        k = 0;
        chk("busy_running", {31'd0, busy}, 32'd1);
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            if (k == inj) begin
                start = 1'b1; a = 8'h10; b = 8'h01;
            end else begin
                start = 1'b0;
            end
        end
        chk("latency", 32'(k), 32'(W + 1));
        chk("diff", {24'd0, diff}, ed);
        chk("borrow", {31'd0, borrow}, {31'd0, eb});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, eo});
`else
        if (eo) k = k + 0;
`endif
        @(negedge clk);
        start = 1'b0;
        chk("done_single_pulse", {31'd0, done}, 32'd0);
        chk("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int extra;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_diff", {24'd0, diff}, 32'd0);
        chk("rst_borrow", {31'd0, borrow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(8'h05, 8'h03, -1);
        do_op(8'h03, 8'h05, -1);
        do_op(8'h00, 8'h00, -1);
        do_op(8'h00, 8'h01, -1);
        do_op(8'hFF, 8'hFF, -1);
        do_op(8'h80, 8'h01, -1);
        do_op(8'h7F, 8'hFF, -1);

        // Start pulsed during SHIFT must be ignored: one done only, first operands' result.
        do_op(8'h20, 8'h01, 3);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        chk("ignored_start_extra_done", 32'(extra), 32'd0);
        chk("ignored_start_diff_held", {24'd0, diff}, 32'h1F);

        // Reset while the bit counter is at 3 aborts immediately.
        @(negedge clk);
        a = 8'h33; b = 8'h11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_diff", {24'd0, diff}, 32'd0);
        chk("abort_borrow", {31'd0, borrow}, 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(8'h09, 8'h04, -1);

        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
